// File: rtl/ucie_debug_trace_capture_if.sv
// Debug-side bundle between the trace capture engine (slave) and the controller (master).
interface ucie_debug_trace_capture_if #(
  parameter int DEPTH = 256,
  parameter int EVT_W = 32
);
  localparam int PTR_W = $clog2(DEPTH);

  logic                  capture_enable;
  logic [EVT_W-1:0]      trigger_mask;
  logic                  event_valid;
  logic [EVT_W-1:0]      event_vec;
  logic                  rd_en;
  logic [PTR_W-1:0]      rd_addr;
  logic [32+EVT_W-1:0]   rd_data;
  logic                  rd_valid;
  logic [PTR_W-1:0]      trace_ptr;
  logic [PTR_W-1:0]      trig_ptr;
  logic [31:0]           timestamp;
  logic [1:0]            cap_state;
  logic                  triggered;
  logic                  wrapped;
  logic                  capture_done;

  modport master (
    output capture_enable, trigger_mask, event_valid, event_vec, rd_en, rd_addr,
    input  rd_data, rd_valid, trace_ptr, trig_ptr, timestamp, cap_state,
           triggered, wrapped, capture_done
  );

  modport slave (
    input  capture_enable, trigger_mask, event_valid, event_vec, rd_en, rd_addr,
    output rd_data, rd_valid, trace_ptr, trig_ptr, timestamp, cap_state,
           triggered, wrapped, capture_done
  );
endinterface

// File: rtl/ucie_debug_trace_capture.sv
// Trace capture engine: timestamped events into a circular RAM, frozen around the
// first trigger hit with a configurable post-trigger window.
module ucie_debug_trace_capture #(
  parameter int DEPTH     = 256,
  parameter int EVT_W     = 32,
  parameter int POST_TRIG = 128
) (
  input logic                     clk,
  input logic                     resetn,
  ucie_debug_trace_capture_if.slave dbg
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = 32 + EVT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } cap_state_t;

  cap_state_t         state;
  cap_state_t         state_next;
  logic               arm;
  logic               trig;
  logic               hit;
  logic               wr_en;

  logic [PTR_W-1:0]   trace_ptr;
  logic [PTR_W-1:0]   trig_ptr;
  logic [PTR_W-1:0]   post_cnt;
  logic               triggered;
  logic               wrapped;
  logic               capture_done;
  logic [31:0]        timestamp;
  logic [ENT_W-1:0]   rd_data;
  logic               rd_valid;

  logic [ENT_W-1:0]   mem [DEPTH];

  assign hit   = dbg.event_valid && |(dbg.event_vec & dbg.trigger_mask);
  // Dropping capture_enable wins over a same-cycle event: nothing is written.
  assign wr_en = dbg.event_valid && dbg.capture_enable &&
                 ((state == ARMED) || (state == POST));

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    arm        = 1'b0;
    trig       = 1'b0;
    case (state)
      IDLE: begin
        if (dbg.capture_enable) begin
          state_next = ARMED;
          arm        = 1'b1;
        end
      end
      ARMED: begin
        if (!dbg.capture_enable) begin
          state_next = IDLE;
        end else if (hit) begin
          trig       = 1'b1;
          state_next = (POST_TRIG == 0) ? DONE : POST;
        end
      end
      POST: begin
        if (!dbg.capture_enable)                      state_next = IDLE;
        else if (wr_en && (post_cnt == PTR_W'(1)))    state_next = DONE;
      end
      DONE: begin
        if (!dbg.capture_enable) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      trace_ptr    <= '0;
      trig_ptr     <= '0;
      post_cnt     <= '0;
      triggered    <= 1'b0;
      wrapped      <= 1'b0;
      capture_done <= 1'b0;
      timestamp    <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
    end else begin
      timestamp <= timestamp + 32'd1;
      rd_valid  <= dbg.rd_en;
      if (dbg.rd_en) rd_data <= mem[dbg.rd_addr];

      if (arm) begin
        trace_ptr    <= '0;
        trig_ptr     <= '0;
        triggered    <= 1'b0;
        wrapped      <= 1'b0;
        capture_done <= 1'b0;
      end else begin
        if (wr_en) begin
          trace_ptr <= trace_ptr + PTR_W'(1);
          if (trace_ptr == PTR_W'(DEPTH - 1)) wrapped <= 1'b1;
        end
        if (trig) begin
          trig_ptr  <= trace_ptr;
          triggered <= 1'b1;
          post_cnt  <= PTR_W'(POST_TRIG);
        end else if ((state == POST) && wr_en) begin
          post_cnt <= post_cnt - PTR_W'(1);
        end
        if (state_next == DONE) capture_done <= 1'b1;
      end
    end
  end

  // RAM is deliberately outside the reset domain; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (resetn && wr_en) mem[trace_ptr] <= {timestamp, dbg.event_vec};
  end

  assign dbg.trace_ptr    = trace_ptr;
  assign dbg.trig_ptr     = trig_ptr;
  assign dbg.timestamp    = timestamp;
  assign dbg.cap_state    = state;
  assign dbg.triggered    = triggered;
  assign dbg.wrapped      = wrapped;
  assign dbg.capture_done = capture_done;
  assign dbg.rd_data      = rd_data;
  assign dbg.rd_valid     = rd_valid;
endmodule
